// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon auto-player: FSM states,
// seven-segment result codes and one-hot helpers.
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        PLAY,
        SETTLE,
        CHECK,
        CLEAR,
        DONE
    } state_t;

    typedef logic [2:0] idx_t;

    localparam logic [6:0] SEG_ZERO = 7'b1000000;
    localparam logic [6:0] SEG_ONE  = 7'b1111001;

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != '0) && ((v & (v - 8'd1)) == '0);
    endfunction

    function automatic idx_t onehot_idx(input logic [7:0] v);
        idx_t r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/simon_flash_detect.sv
// Turns a stable LED value into a single flash (one-hot) or bad (multi-hot)
// strobe on the MIN_ON-th cycle it is held; re-arms on any LED change.
module simon_flash_detect
    import simon_pkg::*;
#(
    parameter int unsigned MIN_ON = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] led,
    output logic       flash,
    output idx_t       idx,
    output logic       bad
);

    localparam int unsigned W = $clog2(MIN_ON) + 1;
    localparam logic [W-1:0] HOLD = W'(MIN_ON);

    logic [7:0]   prev;
    logic [W-1:0] cnt;
    logic         armed;

    logic         same;
    logic         armed_now;
    logic         hit;
    logic [W-1:0] run;

    // run counts the current cycle too, so a strobe fires on the MIN_ON-th sample
    always_comb begin
        same      = (led == prev);
        run       = !same ? W'(1) : ((cnt == HOLD) ? HOLD : cnt + 1'b1);
        armed_now = !same || armed;
        hit       = armed_now && (led != '0) && (run == HOLD);
        flash     = hit && is_onehot(led);
        bad       = hit && !is_onehot(led);
        idx       = onehot_idx(led);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev  <= '0;
            cnt   <= '0;
            armed <= 1'b0;
        end else begin
            prev  <= led;
            cnt   <= run;
            armed <= armed_now && !hit;
        end
    end

endmodule

// File: rtl/simon_auto_player.sv
// Simon auto-player: captures the flashed LED sequence, replays it on SW,
// samples the result digit on seg0 and reports pass/fail/err.
module simon_auto_player
    import simon_pkg::*;
#(
    parameter int unsigned SEQ_LEN         = 7,
    parameter int unsigned MIN_ON          = 4,
    parameter int unsigned STEP_CYCLES     = 2,
    parameter int unsigned SETTLE_CYCLES   = 500,
    parameter int unsigned CAPTURE_TIMEOUT = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] LED,
    input  logic [6:0] seg0,
    output logic [7:0] SW,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       fail,
    output logic       err
);

    if (SEQ_LEN < 1 || SEQ_LEN > 8) begin : g_bad_seq_len
        $error("simon_auto_player: SEQ_LEN must be in 1..8");
    end
    if (MIN_ON == 0 || STEP_CYCLES == 0 || SETTLE_CYCLES == 0 || CAPTURE_TIMEOUT == 0) begin : g_bad_zero
        $error("simon_auto_player: timing parameters must be nonzero");
    end

    localparam int unsigned CW  = $clog2(SEQ_LEN) + 1;
    localparam int unsigned SCW = $clog2(STEP_CYCLES) + 1;
    localparam int unsigned STW = $clog2(SETTLE_CYCLES) + 1;
    localparam int unsigned TW  = $clog2(CAPTURE_TIMEOUT) + 1;

    localparam logic [CW-1:0]  SEQ_LAST   = CW'(SEQ_LEN - 1);
    localparam logic [SCW-1:0] STEP_LAST  = SCW'(STEP_CYCLES - 1);
    localparam logic [STW-1:0] SETTLE_END = STW'(SETTLE_CYCLES);
    localparam logic [TW-1:0]  TMO_LAST   = TW'(CAPTURE_TIMEOUT - 1);

    state_t         state;
    idx_t           seq_buf [8];
    logic [CW-1:0]  count;
    logic [CW-1:0]  ptr;
    logic [SCW-1:0] step_cnt;
    logic [STW-1:0] settle_cnt;
    logic [TW-1:0]  tmo_cnt;
    logic [3:0]     clr_idx;

    logic flash;
    logic bad;
    idx_t flash_idx;
    logic dup;
    logic step_tick;

    simon_flash_detect #(
        .MIN_ON(MIN_ON)
    ) u_detect (
        .clk  (clk),
        .rst  (rst),
        .led  (LED),
        .flash(flash),
        .idx  (flash_idx),
        .bad  (bad)
    );

    always_comb begin
        dup = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (k < 32'(count) && seq_buf[3'(k)] == flash_idx) dup = 1'b1;
        end
    end

    assign step_tick = (step_cnt == STEP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            SW         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            err        <= 1'b0;
            count      <= '0;
            ptr        <= '0;
            step_cnt   <= '0;
            settle_cnt <= '0;
            tmo_cnt    <= '0;
            clr_idx    <= '0;
            for (int unsigned k = 0; k < 8; k++) seq_buf[3'(k)] <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= CAPTURE;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                        fail    <= 1'b0;
                        err     <= 1'b0;
                        count   <= '0;
                        tmo_cnt <= '0;
                    end
                end
                CAPTURE: begin
                    if (bad || (flash && dup)) begin
                        err      <= 1'b1;
                        state    <= CLEAR;
                        step_cnt <= '0;
                        clr_idx  <= '0;
                    end else if (flash) begin
                        seq_buf[3'(count)] <= flash_idx;
                        count              <= count + 1'b1;
                        tmo_cnt            <= '0;
                        if (count == SEQ_LAST) begin
                            state    <= PLAY;
                            step_cnt <= '0;
                            ptr      <= '0;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        err      <= 1'b1;
                        state    <= CLEAR;
                        step_cnt <= '0;
                        clr_idx  <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                PLAY: begin
                    step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
                    if (step_tick) begin
                        SW[seq_buf[3'(ptr)]] <= 1'b1;
                        ptr                  <= ptr + 1'b1;
                        if (ptr == SEQ_LAST) begin
                            state      <= SETTLE;
                            settle_cnt <= '0;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_END) state <= CHECK;
                    else settle_cnt <= settle_cnt + 1'b1;
                end
                CHECK: begin
                    if (seg0 == SEG_ONE)       pass <= 1'b1;
                    else if (seg0 == SEG_ZERO) fail <= 1'b1;
                    else                       err  <= 1'b1;
                    state    <= CLEAR;
                    step_cnt <= '0;
                    clr_idx  <= '0;
                end
                CLEAR: begin
                    // clr_idx == 8 means all bits are down; DONE lands one cycle after SW[7] drops
                    if (clr_idx[3]) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
                        if (step_tick) begin
                            SW[clr_idx[2:0]] <= 1'b0;
                            clr_idx          <= clr_idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_auto_player.sv
// Scoreboard bench for simon_auto_player: stimulus pushes expected SW edits
// and results with their cycle numbers; a negedge monitor pops and compares.
module tb_simon_auto_player;
    import simon_pkg::*;

    localparam int TMO = 400;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] LED;
    logic [6:0] seg0;
    logic [7:0] SW;
    logic       busy;
    logic       done;
    logic       pass;
    logic       fail;
    logic       err;

    logic [6:0] seg_good;

    typedef struct {
        bit         is_result;
        logic [7:0] sw;
        logic [2:0] flags;
        int         when;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    int   seq [7] = '{5, 3, 7, 6, 4, 1, 2};

    // game model: shows the chosen digit only when the expected switch pattern is up
    assign seg0 = (SW == 8'hFE) ? seg_good : 7'h7F;

    simon_auto_player #(
        .SEQ_LEN        (7),
        .MIN_ON         (4),
        .STEP_CYCLES    (2),
        .SETTLE_CYCLES  (500),
        .CAPTURE_TIMEOUT(TMO)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .LED  (LED),
        .seg0 (seg0),
        .SW   (SW),
        .busy (busy),
        .done (done),
        .pass (pass),
        .fail (fail),
        .err  (err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic exp_t mk(input bit r, input logic [7:0] s, input logic [2:0] f, input int w);
        exp_t e;
        e.is_result = r;
        e.sw        = s;
        e.flags     = f;
        e.when      = w;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    logic [7:0] prev_sw   = 8'h00;
    logic       prev_done = 1'b0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (SW !== prev_sw) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sw_unexpected: SW=%h with nothing expected at cycle %0d", SW, cycle);
            end else begin
                e = q.pop_front();
                if (e.is_result) begin
                    checks++; errors++;
                    $display("FAIL sw_order: SW=%h but a result was expected at cycle %0d", SW, cycle);
                end else begin
                    check("sw_value", SW, e.sw);
                    if (e.when >= 0) check("sw_cycle", cycle, e.when);
                end
            end
        end
        if (done === 1'b1 && prev_done !== 1'b1) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL done_unexpected: done rose with nothing expected at cycle %0d", cycle);
            end else begin
                e = q.pop_front();
                if (!e.is_result) begin
                    checks++; errors++;
                    $display("FAIL done_order: done rose but SW=%h was expected at cycle %0d", e.sw, cycle);
                end else begin
                    check("result_flags", {pass, fail, err}, e.flags);
                    check("result_sw", SW, e.sw);
                    check("result_busy", busy, 1'b0);
                    check("done_cycle", cycle, e.when);
                end
            end
        end
        prev_sw   = SW;
        prev_done = done;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++; errors++;
            $display("FAIL wait_done: done=%b after %0d cycles", done, limit);
        end
        repeat (3) @(negedge clk);
    endtask

    // c = cycle of the edge on which the last flash registers
    task automatic push_game(input int c, input logic [2:0] flags, input int n_rise);
        logic [7:0] sw;
        int s;
        sw = 8'h00;
        s  = c + 14;
        for (int k = 0; k < n_rise; k++) begin
            sw[seq[k]] = 1'b1;
            q.push_back(mk(0, sw, 3'b000, c + 2 + 2 * k));
        end
        if (n_rise < 7) return;
        for (int j = 1; j < 8; j++) begin
            sw[j] = 1'b0;
            q.push_back(mk(0, sw, 3'b000, s + 504 + 2 * j));
        end
        q.push_back(mk(1, 8'h00, flags, s + 519));
    endtask

    task automatic run_game(input logic [6:0] good, input logic [2:0] flags,
                            input int n_rise, input bit noise);
        int c;
        seg_good = good;
        pulse_start();
        check("busy_after_start", busy, 1'b1);
        for (int i = 0; i < 7; i++) begin
            LED = 8'd1 << seq[i];
            if (i == 6) begin
                c = cycle + 4;
                push_game(c, flags, n_rise);
            end
            repeat (10) @(negedge clk);
            LED = 8'h00;
            if (i == 6 && n_rise < 7) begin
                repeat (2) @(negedge clk);
                #2;
                q.push_back(mk(0, 8'h00, 3'b000, -1));
                rst = 1'b1;
                #1;
                check("rst_sw", SW, 8'h00);
                check("rst_outputs", {busy, done, pass, fail, err}, 5'b0);
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                repeat (3) @(negedge clk);
                return;
            end
            if (i == 6 && noise) begin
                pulse_start();
                repeat (14) @(negedge clk);
                pulse_start();
            end else begin
                repeat (5) @(negedge clk);
            end
        end
        wait_done(1000);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst      = 1'b1;
        start    = 1'b0;
        LED      = 8'h00;
        seg_good = SEG_ONE;
        repeat (3) @(negedge clk);
        check("reset_outputs", {SW, busy, done, pass, fail, err}, 13'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_game(SEG_ONE, 3'b100, 7, 1'b0);
        run_game(SEG_ZERO, 3'b010, 7, 1'b0);

        seg_good = SEG_ONE;
        pulse_start();
        LED = 8'h08; repeat (3) @(negedge clk);
        LED = 8'h00; repeat (5) @(negedge clk);
        LED = 8'h08; repeat (30) @(negedge clk);
        LED = 8'h00; repeat (5) @(negedge clk);
        LED = 8'h0C;
        q.push_back(mk(1, 8'h00, 3'b001, cycle + 21));
        repeat (4) @(negedge clk);
        LED = 8'h00;
        wait_done(100);

        pulse_start();
        LED = 8'h20; repeat (10) @(negedge clk);
        LED = 8'h00; repeat (5) @(negedge clk);
        LED = 8'h08; repeat (10) @(negedge clk);
        LED = 8'h00; repeat (5) @(negedge clk);
        LED = 8'h20;
        q.push_back(mk(1, 8'h00, 3'b001, cycle + 21));
        repeat (10) @(negedge clk);
        LED = 8'h00;
        wait_done(100);

        q.push_back(mk(1, 8'h00, 3'b001, cycle + TMO + 18));
        pulse_start();
        wait_done(TMO + 100);

        run_game(SEG_ONE, 3'b100, 4, 1'b0);
        run_game(SEG_ONE, 3'b100, 7, 1'b0);
        run_game(SEG_ONE, 3'b100, 7, 1'b1);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
